// File: rtl/meter_controller.sv
// Parking meter sequencing core: remaining-time counter, state FSM and BCD digit outputs.
// Optional build macro PM_EXPIRE_LOCK_EN: adds are ignored while EXPIRED.
module meter_controller #(
  parameter int MAX_COUNT  = 9999,
  parameter int LOW_THRESH = 180,
  parameter int LOAD_A     = 15,
  parameter int LOAD_B     = 150,
  parameter int CW         = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       add_60,
  input  logic       add_120,
  input  logic       add_180,
  input  logic       add_300,
  input  logic       load_a,
  input  logic       load_b,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       state_blink,
  output logic       expired
);

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'd0,
    ST_LOW     = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [CW:0] MAX_W    = (CW+1)'(MAX_COUNT);
  localparam logic [CW:0] THRESH_W = (CW+1)'(LOW_THRESH);
  localparam logic [CW:0] LOAD_A_W = (CW+1)'(LOAD_A);
  localparam logic [CW:0] LOAD_B_W = (CW+1)'(LOAD_B);

  // Shift-and-add-3 conversion; four digits cover the full saturated range.
  function automatic logic [15:0] bin_to_bcd(input logic [CW-1:0] bin);
    logic [15:0] bcd;
    bcd = 16'd0;
    for (int i = CW - 1; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (bcd[4*j +: 4] >= 4'd5) begin
          bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
        end else begin
          bcd[4*j +: 4] = bcd[4*j +: 4];
        end
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] count_r;
  logic [CW:0]   next_count_s;
  logic [CW:0]   add_amt_s;
  logic [CW:0]   sum_s;
  logic          dec_s;
  logic          add_allow_s;
  logic [15:0]   next_bcd_s;
  logic [3:0]    digit3_r, digit2_r, digit1_r, digit0_r;
  logic          blink_r;
  logic          expired_r;

  // Command arbitration and next count computation
  always_comb begin
    next_count_s = {1'b0, count_r};
    add_amt_s    = '0;
    sum_s        = '0;
    dec_s        = tick_1hz && (count_r != '0);
`ifdef PM_EXPIRE_LOCK_EN
    add_allow_s  = (state_r != ST_EXPIRED);
`else
    add_allow_s  = 1'b1;
`endif
    if (add_300) begin
      add_amt_s = (CW+1)'(300);
    end else if (add_180) begin
      add_amt_s = (CW+1)'(180);
    end else if (add_120) begin
      add_amt_s = (CW+1)'(120);
    end else if (add_60) begin
      add_amt_s = (CW+1)'(60);
    end else begin
      add_amt_s = '0;
    end
    sum_s = {1'b0, count_r} + add_amt_s - {{CW{1'b0}}, dec_s};

    if (load_b) begin
      next_count_s = LOAD_B_W;
    end else if (load_a) begin
      next_count_s = LOAD_A_W;
    end else if (add_allow_s && (add_amt_s != '0)) begin
      next_count_s = (sum_s > MAX_W) ? MAX_W : sum_s;
    end else if (dec_s) begin
      next_count_s = {1'b0, count_r} - {{CW{1'b0}}, 1'b1};
    end else begin
      next_count_s = {1'b0, count_r};
    end
    next_bcd_s = bin_to_bcd(next_count_s[CW-1:0]);
  end

  // State derived from the count that is about to be registered
  always_comb begin
    next_state_s = ST_EXPIRED;
    if (next_count_s == '0) begin
      next_state_s = ST_EXPIRED;
    end else if (next_count_s < THRESH_W) begin
      next_state_s = ST_LOW;
    end else begin
      next_state_s = ST_RUN;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EXPIRED;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Count and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r   <= '0;
      digit3_r  <= 4'd0;
      digit2_r  <= 4'd0;
      digit1_r  <= 4'd0;
      digit0_r  <= 4'd0;
      blink_r   <= 1'b1;
      expired_r <= 1'b1;
    end else begin
      count_r   <= next_count_s[CW-1:0];
      digit3_r  <= next_bcd_s[15:12];
      digit2_r  <= next_bcd_s[11:8];
      digit1_r  <= next_bcd_s[7:4];
      digit0_r  <= next_bcd_s[3:0];
      blink_r   <= (next_state_s != ST_RUN);
      expired_r <= (next_state_s == ST_EXPIRED);
    end
  end

  assign digit3      = digit3_r;
  assign digit2      = digit2_r;
  assign digit1      = digit1_r;
  assign digit0      = digit0_r;
  assign state_blink = blink_r;
  assign expired     = expired_r;

endmodule

// File: tb/tb_meter_controller.sv
// Self-checking bench for meter_controller: directed scenarios plus random strobes
// compared against an arithmetic reference model of the remaining time.
module tb_meter_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       add_60 = 1'b0, add_120 = 1'b0, add_180 = 1'b0, add_300 = 1'b0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       state_blink, expired;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;

  always #5 clk = ~clk;

  meter_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .add_60(add_60), .add_120(add_120), .add_180(add_180), .add_300(add_300),
    .load_a(load_a), .load_b(load_b),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .state_blink(state_blink), .expired(expired)
  );

  function automatic int model_next(int cnt, bit r, bit t, bit a60, bit a120,
                                    bit a180, bit a300, bit la, bit lb);
    int amt;
    int res;
    if (!r) return 0;
    if (lb) return 150;
    if (la) return 15;
    amt = a300 ? 300 : a180 ? 180 : a120 ? 120 : a60 ? 60 : 0;
`ifdef PM_EXPIRE_LOCK_EN
    if (cnt == 0) amt = 0;
`endif
    if (amt > 0) begin
      res = cnt + amt - ((t && cnt > 0) ? 1 : 0);
      return (res > 9999) ? 9999 : res;
    end
    if (t && cnt > 0) return cnt - 1;
    return cnt;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (model count %0d)", tag, observed, expected, model);
    end
  endtask

  task automatic check_all(input string tag);
    int shown;
    shown = digit3 * 1000 + digit2 * 100 + digit1 * 10 + digit0;
    check({tag, " digits"}, shown, model);
    check({tag, " blink"}, int'(state_blink), (model < 180) ? 1 : 0);
    check({tag, " expired"}, int'(expired), (model == 0) ? 1 : 0);
  endtask

  // Apply one clock of inputs, update the model, then compare outputs.
  task automatic step(input string tag, input bit r, input bit t, input bit a60,
                      input bit a120, input bit a180, input bit a300,
                      input bit la, input bit lb, input bit do_check);
    @(negedge clk);
    rst_n = r; tick_1hz = t; add_60 = a60; add_120 = a120; add_180 = a180;
    add_300 = a300; load_a = la; load_b = lb;
    @(posedge clk);
    #1;
    rst_n = 1'b1; tick_1hz = 1'b0; add_60 = 1'b0; add_120 = 1'b0;
    add_180 = 1'b0; add_300 = 1'b0; load_a = 1'b0; load_b = 1'b0;
    model = model_next(model, r, t, a60, a120, a180, a300, la, lb);
    if (do_check) check_all(tag);
  endtask

  initial begin
    // 1: reset and first add
    step("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset literal count", digit3 * 1000 + digit2 * 100 + digit1 * 10 + digit0, 0);
    step("add300", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("add300 digit2", int'(digit2), 3);

    // 2: load_b then 151 ticks
    step("loadb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 151; i++)
      step("tick", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i % 10 == 0) || (i >= 148));
    check("after 151 ticks expired", int'(expired), 1);

    // 3: priority
    step("loada+add300", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add60+add300", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // 4: saturation (start from load_a so the locked build also climbs)
    step("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++)
      step("add300 run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("33x add300");
    step("add180 sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add60 sat", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("loada", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++)
      step("add300 run2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("34x add300 from 15");
    check("saturated at 9999", model, 9999);

    // 5: threshold at 180
    step("loadb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("add60", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      step("down", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("at 180");
    step("tick+add60", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tick+add60 value", model, 239);
    for (int i = 0; i < 59; i++)
      step("down", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tick at 180", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tick at 180 blink", int'(state_blink), 1);

    // 6: reset beats add at 500
    step("loadb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("add300", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("add60", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("down", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("at 500");
    step("rst+add60", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("add120 from 0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("loada", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 39) == 0),
           1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
